apb_master: RTL and testbench

- APB requester that drives the existing register-slave side of the bus.
- Accepts single read/write commands on a valid/ready command port.
- Runs each command as one APB SETUP→ACCESS transfer, inserting wait states until pready.
- Returns read data and error status on a valid/ready response port.
- Sits between a local controller (test sequencer or CPU bridge) and APB slaves on the same pclk domain.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_wait_timer.sv | 23 ++
 rtl/apb_master.sv | 108 ++++++++++
 tb/tb_apb_master.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default widths and the response record.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_m_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;
endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter for the APB requester; expire fires on the last allowed wait cycle.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  // Combinational so the FSM leaves ACCESS on the same edge the count reaches the limit.
  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master.sv
// APB requester: one command -> one SETUP/ACCESS transfer -> one response.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);
  apb_m_state_t state;
  apb_rsp_t     rsp_q;
  logic         tmo;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .pclk   (pclk),
    .presetn(presetn),
    .clr    (state == SETUP),
    .en     ((state == ACCESS) && !pready),
    .expire (tmo)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
`endif

  assign rsp_rdata = DATA_W'(rsp_q.rdata);
  assign rsp_err   = rsp_q.err;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            pwrite    <= cmd_write;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over an expiring timeout in the same cycle.
          if (pready) begin
            rsp_q.err   <= pslverr;
            rsp_q.rdata <= pwrite ? '0 : APB_DATA_W'(prdata);
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (tmo) begin
            rsp_q.err   <= 1'b1;
            rsp_q.rdata <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, waited read, slave error, back-pressure,
// timeout (or endless wait without APB_MASTER_TIMEOUT_EN) and asynchronous reset mid-ACCESS.
module tb_apb_master;
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic        pwrite, psel, penable, pready = 1'b0, pslverr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Issue one command and walk it to the RESP cycle; slave raises pready after 'waits' wait states.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int waits,
                      input logic err, input logic [31:0] rd, input logic [31:0] exp_rd);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; pready = 1'b0;
    tick;
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
    chk("setup_sel_en_rdy", 32'({psel, penable, cmd_ready}), 32'b100);
    chk("setup_paddr", paddr, a);
    for (int k = 0; k <= waits; k++) begin
      tick;
      chk("acc_sel_en", 32'({psel, penable}), 32'b11);
      chk("acc_paddr", paddr, a);
      chk("acc_pwrite", 32'(pwrite), 32'(wr));
      if (wr) chk("acc_pwdata", pwdata, d);
      pready = (k == waits); pslverr = err; prdata = rd;
    end
    tick;
    pready = 1'b0; pslverr = 1'b0;
    chk("rsp_vld_sel_en", 32'({rsp_valid, psel, penable}), 32'b100);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(err));
  endtask

  task automatic finish_rsp;
    tick;
    chk("back_idle", 32'({rsp_valid, cmd_ready, psel}), 32'b010);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #12;
    chk("rst_outs", 32'({cmd_ready, psel, penable, rsp_valid, pwrite, rsp_err}), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    tick;

    // zero-wait write
    xfer(1'b1, 32'h0, 32'h1234_5678, 0, 1'b0, 32'h5A5A_5A5A, 32'h0);
    finish_rsp;
    // read with 3 wait states
    xfer(1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    finish_rsp;
    // slave error, then a normal write
    xfer(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h0BAD_0010, 32'h0BAD_0010);
    finish_rsp;
    xfer(1'b1, 32'h44, 32'hCAFE_F00D, 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    finish_rsp;

    // back-pressure; a new command during RESP must be ignored
    rsp_ready = 1'b0;
    xfer(1'b0, 32'h30, 32'h0, 0, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF);
    cmd_valid = 1'b1; cmd_addr = 32'h99; cmd_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld_rdy", 32'({rsp_valid, cmd_ready}), 32'b10);
      chk("bp_rdata", rsp_rdata, 32'h1357_9BDF);
      chk("bp_paddr", paddr, 32'h30);
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    finish_rsp;

    // reset during a wait state
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; pready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("pre_rst_sel_en", 32'({psel, penable}), 32'b11);
    #2 presetn = 1'b0;
    #1;
    chk("async_rst_outs", 32'({psel, penable, rsp_valid, cmd_ready}), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    tick;
    chk("post_rst", 32'({cmd_ready, rsp_valid, psel}), 32'b100);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h70, 32'h0, 0, 1'b0, 32'h0000_0077, 32'h0000_0077);
    finish_rsp;
    prdata = 32'hFFFF_FFFF; pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    tick;
    cmd_valid = 1'b0;
    tick;
    cnt = 0;
    while (penable && cnt < 40) begin
      cnt++;
      tick;
    end
    chk("tmo_access_len", 32'(cnt), 32'd16);
    chk("tmo_vld_sel_en", 32'({rsp_valid, psel, penable}), 32'b100);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    finish_rsp;
`else
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    tick;
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (psel && penable && !rsp_valid) cnt++;
    end
    chk("no_tmo_access_cycles", 32'(cnt), 32'd100);
    chk("no_tmo_still_access", 32'({psel, penable, rsp_valid}), 32'b110);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
